acc_ctrl: RTL



---
 rtl/acc_ctrl_pkg.sv | 35 +++
 rtl/acc_ctrl_skew.sv | 37 +++
 rtl/acc_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/acc_ctrl_pkg.sv
// Shared types for the rate-coded accumulator column sequencer.
// Row-0 control bundle encoding per FSM state lives here so every user agrees on it.
package acc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    MERGE,
    FLUSH
  } acc_ctrl_state_t;

  typedef struct packed {
    logic en;
    logic clr;
    logic mac_done;
  } acc_ctrl_bundle_t;

  localparam acc_ctrl_bundle_t BUNDLE_NONE  = '{en: 1'b0, clr: 1'b0, mac_done: 1'b0};
  localparam acc_ctrl_bundle_t BUNDLE_CLEAR = '{en: 1'b0, clr: 1'b1, mac_done: 1'b0};
  localparam acc_ctrl_bundle_t BUNDLE_ACCUM = '{en: 1'b1, clr: 1'b0, mac_done: 1'b0};
  localparam acc_ctrl_bundle_t BUNDLE_MERGE = '{en: 1'b1, clr: 1'b0, mac_done: 1'b1};

  function automatic acc_ctrl_bundle_t bundle_of(input acc_ctrl_state_t s);
    acc_ctrl_bundle_t b;
    case (s)
      CLEAR:   b = BUNDLE_CLEAR;
      ACCUM:   b = BUNDLE_ACCUM;
      MERGE:   b = BUNDLE_MERGE;
      default: b = BUNDLE_NONE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/acc_ctrl_skew.sv
// Skew chain: tap 0 is the incoming bundle, tap r is that bundle delayed r cycles.
// The whole chain freezes while hold is high so the diagonal schedule stays intact.
module skew_pipe
  import acc_ctrl_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = acc_ctrl_bundle_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  T     din,
  output T     taps [DEPTH]
);

  assign taps[0] = din;

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
    T stage_d;
    T stage_q;

    always_comb begin
      stage_d = hold ? stage_q : taps[gi-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign taps[gi] = stage_q;
  end

endmodule

// File: rtl/acc_ctrl.sv
// Column sequencer: clear / accumulate / merge / flush schedule for ROWS accumulators,
// skewed one cycle per row, with a global stall that freezes everything.
module acc_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int ROWS  = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] stream_len,
  input  logic             stall,
  output logic [ROWS-1:0]  en,
  output logic [ROWS-1:0]  clr,
  output logic [ROWS-1:0]  mac_done,
  output logic             busy,
  output logic             done
);

  localparam int FW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS - 1);

  acc_ctrl_state_t  state_q, state_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  acc_ctrl_bundle_t bundle_q, bundle_d;
  logic             busy_q, busy_d;
  logic             term_q, term_d;

  always_comb begin
    state_d     = state_q;
    acc_cnt_d   = acc_cnt_q;
    flush_cnt_d = flush_cnt_q;
    len_d       = len_q;
    if (!stall) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = CLEAR;
            len_d   = stream_len;
          end
        end
        CLEAR: begin
          if (len_q == '0) begin
            state_d = MERGE;
          end else begin
            state_d   = ACCUM;
            acc_cnt_d = '0;
          end
        end
        ACCUM: begin
          if (acc_cnt_q == len_q - CNT_W'(1)) begin
            state_d = MERGE;
          end else begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
          end
        end
        MERGE: begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
        FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_d = IDLE;
          end else begin
            flush_cnt_d = flush_cnt_q + FW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Outputs are decoded from the next state so they leave the flops aligned with it.
    bundle_d = bundle_of(state_d);
    busy_d   = (state_d != IDLE);
    term_d   = (state_d == FLUSH) && (flush_cnt_d == FLUSH_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_cnt_q   <= '0;
      flush_cnt_q <= '0;
      len_q       <= '0;
      bundle_q    <= '0;
      busy_q      <= 1'b0;
      term_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_cnt_q   <= acc_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      len_q       <= len_d;
      bundle_q    <= bundle_d;
      busy_q      <= busy_d;
      term_q      <= term_d;
    end
  end

  acc_ctrl_bundle_t taps [ROWS];

  skew_pipe #(
    .DEPTH (ROWS),
    .T     (acc_ctrl_bundle_t)
  ) u_skew (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (stall),
    .din   (bundle_q),
    .taps  (taps)
  );

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_gate
    assign en[gi]       = taps[gi].en       & ~stall;
    assign clr[gi]      = taps[gi].clr      & ~stall;
    assign mac_done[gi] = taps[gi].mac_done & ~stall;
  end

  assign busy = busy_q;
  assign done = term_q & ~stall;

endmodule
